exe_mem_pipe_reg: RTL and testbench

- Execute-to-memory pipeline boundary of the Y86-64 pipelined core.
- Holds the M pipeline register, which captures the execute stage's results every cycle. Supports stall and bubble injection from pipeline control.
- Owns the architectural condition-code register {ZF,SF,OF}. This register is written from the ALU flag vector during OPq and gated by downstream exception status.
- The CC output drives the execute stage's CND logic. The M outputs drive the memory stage and forwarding.

---
 rtl/exe_mem_pipe_reg_if.sv | 30 +++
 rtl/exe_mem_pipe_reg.sv | 98 +++++++++
 tb/tb_exe_mem_pipe_reg.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/exe_mem_pipe_reg_if.sv
// Execute-to-memory bundle: execute-stage results in, M pipeline register fields out.
interface exe_mem_pipe_reg_if #(
    parameter int unsigned W = 64
);
    logic [3:0]   E_icode;
    logic [2:0]   e_stat;
    logic         e_cnd;
    logic [W-1:0] e_valE;
    logic [W-1:0] E_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   E_dstM;

    logic [2:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    modport master (
        output E_icode, e_stat, e_cnd, e_valE, E_valA, e_dstE, E_dstM,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_icode, e_stat, e_cnd, e_valE, E_valA, e_dstE, E_dstM,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/exe_mem_pipe_reg.sv
// Y86-64 execute-to-memory pipeline register with stall/bubble control,
// plus the architectural condition-code register {ZF,SF,OF}.
module exe_mem_pipe_reg #(
    parameter int unsigned W        = 64,
    parameter logic [2:0]  CC_RESET = 3'b100
) (
    input  logic                clk,
    input  logic                rst_n,
    exe_mem_pipe_reg_if.slave   bus,
    input  logic [2:0]          alu_cf,
    input  logic [2:0]          m_stat,
    input  logic [2:0]          W_stat,
    input  logic                M_stall,
    input  logic                M_bubble,
    output logic [2:0]          cc
);
    localparam logic [2:0] SBUB   = 3'd0;
    localparam logic [2:0] SHLT   = 3'd2;
    localparam logic [2:0] SADR   = 3'd3;
    localparam logic [2:0] SINS   = 3'd4;
    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_OPQ  = 4'h6;

    typedef struct packed {
        logic [2:0]   stat;
        logic [3:0]   icode;
        logic         cnd;
        logic [W-1:0] val_e;
        logic [W-1:0] val_a;
        logic [3:0]   dst_e;
        logic [3:0]   dst_m;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{
        stat:  SBUB,
        icode: I_NOP,
        cnd:   1'b0,
        val_e: '0,
        val_a: '0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    m_reg_t m_q;
    m_reg_t m_d;
    m_reg_t e_in;
    logic   m_exc_c;
    logic   w_exc_c;
    logic   set_cc_c;

    assign e_in = '{
        stat:  bus.e_stat,
        icode: bus.E_icode,
        cnd:   bus.e_cnd,
        val_e: bus.e_valE,
        val_a: bus.E_valA,
        dst_e: bus.e_dstE,
        dst_m: bus.E_dstM
    };

    // Next M value: bubble beats stall, stall beats load.
    always_comb begin
        m_d = e_in;
        if (M_bubble) begin
            m_d = M_BUBBLE;
        end else if (M_stall) begin
            m_d = m_q;
        end
    end

    // An OPq behind a faulting instruction must not touch CC.
    always_comb begin
        m_exc_c  = (m_stat == SADR) || (m_stat == SINS) || (m_stat == SHLT);
        w_exc_c  = (W_stat == SADR) || (W_stat == SINS) || (W_stat == SHLT);
        set_cc_c = (bus.E_icode == I_OPQ) && !m_exc_c && !w_exc_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q <= M_BUBBLE;
            cc  <= CC_RESET;
        end else begin
            m_q <= m_d;
            if (set_cc_c) begin
                cc <= alu_cf;
            end
        end
    end

    assign bus.M_stat  = m_q.stat;
    assign bus.M_icode = m_q.icode;
    assign bus.M_cnd   = m_q.cnd;
    assign bus.M_valE  = m_q.val_e;
    assign bus.M_valA  = m_q.val_a;
    assign bus.M_dstE  = m_q.dst_e;
    assign bus.M_dstM  = m_q.dst_m;
endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Scoreboard bench for exe_mem_pipe_reg: expected M/CC state is queued at drive time
// and compared one edge later.
module tb_exe_mem_pipe_reg;
    localparam int unsigned W = 64;

    typedef struct packed {
        logic [2:0]   stat;
        logic [3:0]   icode;
        logic         cnd;
        logic [W-1:0] val_e;
        logic [W-1:0] val_a;
        logic [3:0]   dst_e;
        logic [3:0]   dst_m;
        logic [2:0]   cc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] alu_cf;
    logic [2:0] m_stat;
    logic [2:0] W_stat;
    logic       M_stall;
    logic       M_bubble;
    logic [2:0] cc;

    int   check_cnt = 0;
    int   err_cnt   = 0;
    exp_t sb_q[$];
    exp_t mdl;

    exe_mem_pipe_reg_if #(.W(W)) bus ();

    exe_mem_pipe_reg #(.W(W), .CC_RESET(3'b100)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_cf   (alu_cf),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .M_stall  (M_stall),
        .M_bubble (M_bubble),
        .cc       (cc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic is_exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    // Reference behaviour for one rising edge given the currently driven inputs.
    function automatic exp_t predict(input exp_t cur);
        exp_t n;
        n = cur;
        if (!rst_n) begin
            n = '{stat: 3'd0, icode: 4'h1, cnd: 1'b0, val_e: '0, val_a: '0,
                  dst_e: 4'hF, dst_m: 4'hF, cc: 3'b100};
        end else begin
            if (M_bubble) begin
                n.stat = 3'd0; n.icode = 4'h1; n.cnd = 1'b0; n.val_e = '0;
                n.val_a = '0; n.dst_e = 4'hF; n.dst_m = 4'hF;
            end else if (!M_stall) begin
                n.stat = bus.e_stat; n.icode = bus.E_icode; n.cnd = bus.e_cnd;
                n.val_e = bus.e_valE; n.val_a = bus.E_valA;
                n.dst_e = bus.e_dstE; n.dst_m = bus.E_dstM;
            end
            if (bus.E_icode == 4'h6 && !is_exc(m_stat) && !is_exc(W_stat)) begin
                n.cc = alu_cf;
            end
        end
        return n;
    endfunction

    task automatic step(input string tag);
        exp_t e;
        mdl = predict(mdl);
        sb_q.push_back(mdl);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_cnt++;
            err_cnt++;
            $display("FAIL %s: scoreboard empty, got 1 expected 0", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".stat"},  W'(bus.M_stat),  W'(e.stat));
            check({tag, ".icode"}, W'(bus.M_icode), W'(e.icode));
            check({tag, ".cnd"},   W'(bus.M_cnd),   W'(e.cnd));
            check({tag, ".valE"},  bus.M_valE,      e.val_e);
            check({tag, ".valA"},  bus.M_valA,      e.val_a);
            check({tag, ".dstE"},  W'(bus.M_dstE),  W'(e.dst_e));
            check({tag, ".dstM"},  W'(bus.M_dstM),  W'(e.dst_m));
            check({tag, ".cc"},    W'(cc),          W'(e.cc));
        end
    endtask

    task automatic rand_exe();
        bus.E_icode = 4'($urandom);
        bus.e_stat  = 3'($urandom);
        bus.e_cnd   = 1'($urandom);
        bus.e_valE  = {$urandom, $urandom};
        bus.E_valA  = {$urandom, $urandom};
        bus.e_dstE  = 4'($urandom);
        bus.E_dstM  = 4'($urandom);
        alu_cf      = 3'($urandom);
    endtask

    task automatic set_exe(input logic [3:0] icode, input logic [2:0] stat, input logic cnd,
                           input logic [W-1:0] ve, input logic [W-1:0] va,
                           input logic [3:0] de, input logic [3:0] dm, input logic [2:0] cf);
        bus.E_icode = icode; bus.e_stat = stat; bus.e_cnd = cnd;
        bus.e_valE = ve; bus.E_valA = va; bus.e_dstE = de; bus.E_dstM = dm;
        alu_cf = cf;
    endtask

    task automatic ctl(input logic rn, input logic st, input logic bb,
                       input logic [2:0] ms, input logic [2:0] ws);
        rst_n = rn; M_stall = st; M_bubble = bb; m_stat = ms; W_stat = ws;
    endtask

    initial begin
        mdl = '0;
        ctl(1'b0, 1'b1, 1'b0, 3'd1, 3'd1);
        rand_exe();
        #2;

        // Reset with random inputs and control.
        for (int i = 0; i < 2; i++) begin
            rand_exe();
            M_stall = 1'($urandom); M_bubble = 1'($urandom);
            step("reset");
        end

        // Pass-through, also an OPq setting cc to 010.
        ctl(1'b1, 1'b0, 1'b0, 3'd1, 3'd1);
        set_exe(4'h6, 3'd1, 1'b1, 64'h1234, 64'h5, 4'h3, 4'hF, 3'b010);
        step("pass");

        set_exe(4'h3, 3'd1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h77, 4'h2, 4'h4, 3'b111);
        step("no_opq");

        // Stall with changing inputs.
        for (int i = 0; i < 3; i++) begin
            ctl(1'b1, 1'b1, 1'b0, 3'd1, 3'd1);
            rand_exe();
            step("stall");
        end

        ctl(1'b1, 1'b1, 1'b1, 3'd1, 3'd1);
        rand_exe();
        step("stall_bubble");

        // Exception gating of cc.
        ctl(1'b1, 1'b0, 1'b0, 3'd3, 3'd1);
        set_exe(4'h6, 3'd1, 1'b0, 64'h1, 64'h2, 4'h0, 4'hF, 3'b001);
        step("gate_m_sadr");
        ctl(1'b1, 1'b0, 1'b0, 3'd1, 3'd4);
        step("gate_w_sins");
        ctl(1'b1, 1'b0, 1'b0, 3'd2, 3'd1);
        step("gate_m_shlt");
        ctl(1'b1, 1'b0, 1'b0, 3'd1, 3'd1);
        step("gate_open");

        // cc updates even while M is stalled or bubbled.
        ctl(1'b1, 1'b1, 1'b0, 3'd0, 3'd1);
        set_exe(4'h6, 3'd1, 1'b0, 64'h9, 64'h8, 4'h1, 4'hF, 3'b110);
        step("cc_in_stall");
        ctl(1'b1, 1'b0, 1'b1, 3'd1, 3'd0);
        set_exe(4'h6, 3'd1, 1'b0, 64'h9, 64'h8, 4'h1, 4'hF, 3'b011);
        step("cc_in_bubble");

        // Reset while stalled on valid data.
        ctl(1'b1, 1'b0, 1'b0, 3'd1, 3'd1);
        set_exe(4'h5, 3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hABCD, 4'h7, 4'h8, 3'b000);
        step("load_valid");
        ctl(1'b0, 1'b1, 1'b0, 3'd1, 3'd1);
        rand_exe();
        step("reset_stall");

        // Random traffic including undefined icodes and stat values.
        for (int i = 0; i < 60; i++) begin
            ctl(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                3'($urandom), 3'($urandom));
            if ($urandom_range(0, 29) == 0) rst_n = 1'b0;
            rand_exe();
            if ($urandom_range(0, 2) == 0) bus.E_icode = 4'h6;
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end
endmodule
